// File: rtl/alu_dispatch_fifo_if.sv
// Payload type and handshake bundle between rename, the dispatch FIFO and the ALU
// reservation station. The slave modport is the FIFO's view.
package alu_dispatch_pkg;
    typedef struct packed {
        logic [5:0]  rob_index;
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [6:0]  prd;
        logic [6:0]  prs1;
        logic [6:0]  prs2;
        logic [31:0] imm;
    } dispatch_pipeline_data;
endpackage

interface alu_dispatch_fifo_if
    import alu_dispatch_pkg::*;
#(
    parameter int DEPTH = 8
);
    logic                       flush;
    logic                       enq_valid_1;
    logic                       enq_valid_2;
    dispatch_pipeline_data      enq_instr1;
    dispatch_pipeline_data      enq_instr2;
    logic                       enq_ready;
    logic                       valid_out_1;
    logic                       valid_out_2;
    dispatch_pipeline_data      instr_out1;
    dispatch_pipeline_data      instr_out2;
    logic                       rs_ready_1;
    logic                       rs_ready_2;
    logic [$clog2(DEPTH):0]     count;

    modport slave (
        input  flush, enq_valid_1, enq_valid_2, enq_instr1, enq_instr2,
        input  rs_ready_1, rs_ready_2,
        output enq_ready, valid_out_1, valid_out_2, instr_out1, instr_out2, count
    );

    modport master (
        output flush, enq_valid_1, enq_valid_2, enq_instr1, enq_instr2,
        output rs_ready_1, rs_ready_2,
        input  enq_ready, valid_out_1, valid_out_2, instr_out1, instr_out2, count
    );
endinterface

// File: rtl/alu_dispatch_fifo.sv
// Two-wide in-order circular dispatch queue feeding the ALU reservation station.
// Outputs come only from registered state; the RS consumes the head entries combinationally.
module alu_dispatch_fifo
    import alu_dispatch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    alu_dispatch_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    dispatch_pipeline_data mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW:0]   count_sum;

    logic          enq_ready;
    logic          push_ok;
    logic          pop1, pop2;
    logic [1:0]    n_push, n_pop;
    logic [1:0]    wr_en;
    dispatch_pipeline_data wr_data [2];
    dispatch_pipeline_data rd_data [2];
    logic [1:0]    rd_valid;

    // No credit for same-cycle pops: readiness is a pure function of stored occupancy.
    assign enq_ready = (count_q <= READY_MAX);
    assign push_ok   = enq_ready && !bus.flush;

    // A lone slot-2 entry is compacted into the tail slot.
    assign wr_en[0]   = push_ok && (bus.enq_valid_1 || bus.enq_valid_2);
    assign wr_en[1]   = push_ok && bus.enq_valid_1 && bus.enq_valid_2;
    assign wr_data[0] = bus.enq_valid_1 ? bus.enq_instr1 : bus.enq_instr2;
    assign wr_data[1] = bus.enq_instr2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rd_data[gi]  = mem_q[head_q + PW'(gi)];
        assign rd_valid[gi] = (count_q > CW'(gi));
    end

    assign pop1 = rd_valid[0] && bus.rs_ready_1;
    assign pop2 = pop1 && rd_valid[1] && bus.rs_ready_2;

    assign n_push = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
    assign n_pop  = {1'b0, pop1} + {1'b0, pop2};

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_sum = {1'b0, count_q} + (CW+1)'(n_push) - (CW+1)'(n_pop);
        count_d   = count_sum[CW] ? '0 : count_sum[CW-1:0];
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d = head_q + PW'(n_pop);
            tail_d = tail_q + PW'(n_push);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; stale contents are masked by the valid outputs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                mem_q[tail_q + PW'(i)] <= wr_data[i];
            end
        end
    end

    assign bus.enq_ready   = enq_ready;
    assign bus.valid_out_1 = rd_valid[0];
    assign bus.valid_out_2 = rd_valid[1];
    assign bus.instr_out1  = rd_data[0];
    assign bus.instr_out2  = rd_data[1];
    assign bus.count       = count_q;
endmodule

// File: tb/tb_alu_dispatch_fifo.sv
// Directed bench: the driver pushes expected entries into a scoreboard queue and a
// negedge monitor pops and compares each entry the reservation station would consume.
module tb_alu_dispatch_fifo;
    import alu_dispatch_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_dispatch_fifo_if #(.DEPTH(8)) bus();

    alu_dispatch_fifo #(.DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dispatch_pipeline_data exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic dispatch_pipeline_data mk(input int rob);
        dispatch_pipeline_data d;
        d.rob_index = 6'(rob);
        d.pc        = 32'h1000 + 32'(rob) * 4;
        d.alu_op    = 4'(rob);
        d.prd       = 7'(rob + 7);
        d.prs1      = 7'(rob + 19);
        d.prs2      = 7'(rob * 3);
        d.imm       = 32'(rob) * 32'h0101_0101;
        return d;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic pop_chk(input string name, input dispatch_pipeline_data act);
        dispatch_pipeline_data exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got rob %0d, expected no entry to pop (t=%0t)",
                     name, act.rob_index, $time);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got rob %0d (%h), expected rob %0d (%h) (t=%0t)",
                         name, act.rob_index, act, exp.rob_index, exp, $time);
            end else begin
                $display("ok   %s rob %0d", name, act.rob_index);
            end
        end
    endtask

    // The RS samples instr_out on the edge where a pop happens; check just before it.
    always @(negedge clk) begin
        if (reset && !bus.flush) begin
            if (bus.valid_out_1 && bus.rs_ready_1) begin
                pop_chk("pop lane1", bus.instr_out1);
                if (bus.valid_out_2 && bus.rs_ready_2) begin
                    pop_chk("pop lane2", bus.instr_out2);
                end
            end
        end
    end

    // acc is the hand-derived expectation of whether this push is accepted.
    task automatic drive(input bit v1, input int r1, input bit v2, input int r2,
                         input bit rr1, input bit rr2, input bit fl, input bit acc);
        bus.enq_valid_1 = v1;
        bus.enq_instr1  = mk(r1);
        bus.enq_valid_2 = v2;
        bus.enq_instr2  = mk(r2);
        bus.rs_ready_1  = rr1;
        bus.rs_ready_2  = rr2;
        bus.flush       = fl;
        if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            if (v1) exp_q.push_back(mk(r1));
            if (v2) exp_q.push_back(mk(r2));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.enq_valid_1 = 1'b0;
        bus.enq_valid_2 = 1'b0;
        bus.enq_instr1  = mk(0);
        bus.enq_instr2  = mk(0);
        bus.rs_ready_1  = 1'b0;
        bus.rs_ready_2  = 1'b0;
        bus.flush       = 1'b0;

        // Reset held for three cycles
        #1;
        chk("in-reset count", int'(bus.count), 0);
        chk("in-reset enq_ready", int'(bus.enq_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("post-reset count", int'(bus.count), 0);
        chk("post-reset valid_out_1", int'(bus.valid_out_1), 0);
        chk("post-reset enq_ready", int'(bus.enq_ready), 1);

        // Single entry, one-cycle visibility
        drive(1, 3, 0, 0, 0, 0, 0, 1);
        chk("single valid_out_1", int'(bus.valid_out_1), 1);
        chk("single valid_out_2", int'(bus.valid_out_2), 0);
        chk("single instr_out1 rob", int'(bus.instr_out1.rob_index), 3);
        chk("single count", int'(bus.count), 1);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("single drained count", int'(bus.count), 0);

        // Fill to full with four pairs
        for (int p = 0; p < 4; p++) begin
            drive(1, 2*p, 1, 2*p+1, 0, 0, 0, 1);
            chk($sformatf("fill%0d count", p), int'(bus.count), 2*(p+1));
            chk($sformatf("fill%0d enq_ready", p), int'(bus.enq_ready), (p < 3) ? 1 : 0);
        end
        drive(1, 8, 1, 9, 0, 0, 0, 0);
        chk("full held pair count", int'(bus.count), 8);
        chk("full enq_ready", int'(bus.enq_ready), 0);

        // In-order drain; count=7 still refuses a pair even with a double pop
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("drain count 7", int'(bus.count), 7);
        chk("count7 enq_ready", int'(bus.enq_ready), 0);
        drive(1, 60, 1, 61, 1, 1, 0, 0);
        chk("near-full double pop count", int'(bus.count), 5);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("drain count 4", int'(bus.count), 4);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            chk($sformatf("ready2-only count %0d", k), int'(bus.count), 4);
        end
        drive(1, 62, 0, 0, 0, 0, 0, 1);
        chk("pre-flush count", int'(bus.count), 5);

        // Flush beats push and pop
        drive(1, 40, 1, 41, 1, 0, 1, 0);
        chk("flush count", int'(bus.count), 0);
        chk("flush valid_out_1", int'(bus.valid_out_1), 0);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        chk("post-flush count", int'(bus.count), 0);
        chk("post-flush valid_out_1", int'(bus.valid_out_1), 0);

        // Slot-2-only compaction
        drive(0, 0, 1, 5, 0, 0, 0, 1);
        chk("compact instr_out1 rob", int'(bus.instr_out1.rob_index), 5);
        chk("compact valid_out_2", int'(bus.valid_out_2), 0);
        chk("compact count", int'(bus.count), 1);
        drive(1, 6, 0, 0, 0, 0, 0, 1);
        chk("steady start count", int'(bus.count), 2);
        chk("steady start instr_out2 rob", int'(bus.instr_out2.rob_index), 6);

        // Steady two-in/two-out across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1, 10 + 2*i, 1, 11 + 2*i, 1, 1, 0, 1);
            chk($sformatf("steady%0d count", i), int'(bus.count), 2);
        end
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        chk("steady drained count", int'(bus.count), 0);
        chk("scoreboard drained", exp_q.size(), 0);

        // Reset pulsed between edges while holding five entries
        drive(1, 50, 1, 51, 0, 0, 0, 1);
        drive(1, 52, 1, 53, 0, 0, 0, 1);
        drive(1, 54, 0, 0, 0, 0, 0, 1);
        bus.enq_valid_1 = 1'b0;
        chk("pre-reset count", int'(bus.count), 5);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("async reset count", int'(bus.count), 0);
        chk("async reset valid_out_1", int'(bus.valid_out_1), 0);
        chk("async reset valid_out_2", int'(bus.valid_out_2), 0);
        chk("async reset enq_ready", int'(bus.enq_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        chk("after reset count", int'(bus.count), 0);
        chk("after reset valid_out_1", int'(bus.valid_out_1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
